// File: rtl/mem_reader_if.sv
// Handshake bundle for mem_reader: command/status, Avalon-MM read master and output stream.
// The master modport is the reader's view; the slave modport is the surrounding system's view.
interface mem_reader_if;
    logic        start;
    logic [28:0] base_addr;
    logic [15:0] num_words;
    logic        busy;
    logic        done;
    logic [28:0] avm_addr;
    logic        avm_read;
    logic [63:0] avm_readdata;
    logic        avm_readdatavalid;
    logic        avm_waitrequest;
    logic        out_valid;
    logic [63:0] out_data;
    logic        out_ready;

    modport master (
        input  start, base_addr, num_words,
        input  avm_readdata, avm_readdatavalid, avm_waitrequest,
        input  out_ready,
        output busy, done, avm_addr, avm_read, out_valid, out_data
    );

    modport slave (
        output start, base_addr, num_words,
        output avm_readdata, avm_readdatavalid, avm_waitrequest,
        output out_ready,
        input  busy, done, avm_addr, avm_read, out_valid, out_data
    );
endinterface

// File: rtl/mem_reader.sv
// Burst reader: issues pipelined Avalon-MM reads of 64-bit words and streams the responses
// out through a first-word-fall-through FIFO sized so that it can never overflow.
module mem_reader #(
    parameter int FIFO_DEPTH      = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic         clk,
    input  logic         reset,
    mem_reader_if.master bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int LVL_W = CNT_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [28:0]        addr_q, addr_d;
    logic [15:0]        req_left_q, req_left_d;
    logic [15:0]        resp_left_q, resp_left_d;
    logic [OUT_W-1:0]   outst_q, outst_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic               read_q, read_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               valid_q, valid_d;
    logic [63:0]        data_q, data_d;
    logic [63:0]        mem_q [FIFO_DEPTH];
    logic [LVL_W-1:0]   level_s;
    logic               accept_s;
    logic               wr_en_s;
    logic               pop_s;

    assign accept_s = read_q & ~bus.avm_waitrequest;
    assign wr_en_s  = bus.avm_readdatavalid & (outst_q != {OUT_W{1'b0}});
    assign pop_s    = valid_q & bus.out_ready;

    // Control FSM: command acceptance, address/request bookkeeping and completion.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        req_left_d  = req_left_q;
        resp_left_d = resp_left_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start && (bus.num_words != 16'd0)) begin
                    state_d     = S_FETCH;
                    addr_d      = bus.base_addr & ~29'h7;
                    req_left_d  = bus.num_words;
                    resp_left_d = bus.num_words;
                end else begin
                    done_d = bus.start;
                end
            end
            S_FETCH: begin
                if (accept_s) begin
                    addr_d     = addr_q + 29'd8;
                    req_left_d = req_left_q - 16'd1;
                end else begin
                    addr_d = addr_q;
                end
                if (wr_en_s) begin
                    resp_left_d = resp_left_q - 16'd1;
                    state_d     = (resp_left_q == 16'd1) ? S_DRAIN : S_FETCH;
                end else begin
                    resp_left_d = resp_left_q;
                end
            end
            S_DRAIN: begin
                if ((cnt_q == {CNT_W{1'b0}}) || (pop_s && (cnt_q == CNT_W'(1)))) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath: outstanding/FIFO counters, pointers, FWFT head and read-request qualification.
    always_comb begin
        case ({accept_s, wr_en_s})
            2'b10:   outst_d = outst_q + OUT_W'(1);
            2'b01:   outst_d = outst_q - OUT_W'(1);
            default: outst_d = outst_q;
        endcase
        case ({wr_en_s, pop_s})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        wr_ptr_d = wr_ptr_q + PTR_W'(wr_en_s);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_s);
        // A word landing on the next head slot bypasses the array so it is visible next cycle.
        if (wr_en_s && (wr_ptr_q == rd_ptr_d)) begin
            data_d = bus.avm_readdata;
        end else begin
            data_d = mem_q[rd_ptr_d];
        end
        valid_d = (cnt_d != {CNT_W{1'b0}});
        level_s = LVL_W'(outst_d) + LVL_W'(cnt_d);
        if (read_q && bus.avm_waitrequest) begin
            read_d = 1'b1;
        end else begin
            read_d = (state_d == S_FETCH) && (req_left_d != 16'd0) &&
                     (outst_d < OUT_W'(MAX_OUTSTANDING)) && (level_s < LVL_W'(FIFO_DEPTH));
        end
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= 29'd0;
            req_left_q  <= 16'd0;
            resp_left_q <= 16'd0;
            outst_q     <= {OUT_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            read_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            valid_q     <= 1'b0;
            data_q      <= 64'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            req_left_q  <= req_left_d;
            resp_left_q <= resp_left_d;
            outst_q     <= outst_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            read_q      <= read_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= bus.avm_readdata;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.avm_addr  = addr_q;
    assign bus.avm_read  = read_q;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
endmodule

// File: tb/tb_mem_reader.sv
// Self-checking bench for mem_reader: Avalon slave model with fixed latency and stall control,
// plus address and data scoreboards filled when each fetch is launched.
module tb_mem_reader;
    localparam int MAX_OUT = 4;

    typedef struct {
        int          due;
        logic [28:0] addr;
    } rsp_t;

    logic clk;
    logic reset;
    mem_reader_if bus_if();

    mem_reader #(.FIFO_DEPTH(8), .MAX_OUTSTANDING(MAX_OUT)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if.master)
    );

    int          n_total = 0;
    int          n_bad   = 0;
    logic [63:0] exp_q[$];
    logic [28:0] addr_exp_q[$];
    rsp_t        pipe[$];
    int          cyc = 0;
    int          lat = 2;
    int          stall_left = 0;
    logic        rdy_en = 1'b1;
    int          model_outst = 0;
    int          acc_cnt = 0;
    int          pop_cnt = 0;
    int          done_cnt = 0;
    int          wait_run = 0;
    int          last_wait = -1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] data_of(input logic [28:0] a);
        return {a, 6'h2A, a};
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Launch one fetch; expectations are queued as the command is driven.
    task automatic launch(input logic [28:0] base, input logic [15:0] n);
        logic [28:0] a;
        a = base & ~29'h7;
        bus_if.start     = 1'b1;
        bus_if.base_addr = base;
        bus_if.num_words = n;
        for (int i = 0; i < int'(n); i++) begin
            addr_exp_q.push_back(a);
            exp_q.push_back(data_of(a));
            a = a + 29'd8;
        end
        tick();
        bus_if.start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        int k;
        d0 = done_cnt;
        k  = 0;
        while ((done_cnt == d0) && (k < budget)) begin
            tick();
            k++;
        end
        if (done_cnt == d0) check_val("done_timeout", 64'd0, 64'd1);
    endtask

    // Slave/consumer model: runs mid-cycle, drives inputs for the coming edge and scores outputs.
    initial begin
        rsp_t r;
        logic        prev_stall;
        logic [28:0] prev_addr;
        prev_stall = 1'b0;
        prev_addr  = 29'd0;
        bus_if.avm_waitrequest   = 1'b0;
        bus_if.avm_readdatavalid = 1'b0;
        bus_if.avm_readdata      = 64'd0;
        bus_if.out_ready         = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if ((pipe.size() > 0) && (pipe[0].due <= cyc)) begin
                r = pipe.pop_front();
                bus_if.avm_readdatavalid = 1'b1;
                bus_if.avm_readdata      = data_of(r.addr);
                if (model_outst > 0) model_outst--;
            end else begin
                bus_if.avm_readdatavalid = 1'b0;
                bus_if.avm_readdata      = 64'd0;
            end
            if (bus_if.avm_read && (stall_left > 0)) begin
                bus_if.avm_waitrequest = 1'b1;
                stall_left--;
            end else begin
                bus_if.avm_waitrequest = 1'b0;
            end
            if (prev_stall && !reset) begin
                check_val("hold_read", {63'd0, bus_if.avm_read}, 64'd1);
                check_val("hold_addr", {35'd0, bus_if.avm_addr}, {35'd0, prev_addr});
            end
            prev_stall = bus_if.avm_read && bus_if.avm_waitrequest;
            prev_addr  = bus_if.avm_addr;
            if (bus_if.avm_read && !bus_if.avm_waitrequest) begin
                check_val("max_outst", {63'd0, model_outst < MAX_OUT}, 64'd1);
                if (addr_exp_q.size() == 0) begin
                    check_val("addr_unexp", 64'd1, 64'd0);
                end else begin
                    check_val("addr", {35'd0, bus_if.avm_addr}, {35'd0, addr_exp_q.pop_front()});
                end
                pipe.push_back('{due: cyc + lat, addr: bus_if.avm_addr});
                model_outst++;
                acc_cnt++;
                last_wait = wait_run;
                wait_run  = 0;
            end else if (bus_if.avm_read) begin
                wait_run++;
            end
            bus_if.out_ready = rdy_en;
            if (bus_if.out_valid && rdy_en) begin
                pop_cnt++;
                if (exp_q.size() == 0) begin
                    check_val("pop_unexp", 64'd1, 64'd0);
                end else begin
                    check_val("word", bus_if.out_data, exp_q.pop_front());
                end
            end
            if (bus_if.done) done_cnt++;
        end
    end

    initial begin
        int a0;
        int p0;
        int d0;
        int k;
        reset            = 1'b1;
        bus_if.start     = 1'b0;
        bus_if.base_addr = 29'd0;
        bus_if.num_words = 16'd0;
        repeat (3) tick();
        check_val("rst_busy",  {63'd0, bus_if.busy},      64'd0);
        check_val("rst_done",  {63'd0, bus_if.done},      64'd0);
        check_val("rst_read",  {63'd0, bus_if.avm_read},  64'd0);
        check_val("rst_addr",  {35'd0, bus_if.avm_addr},  64'd0);
        check_val("rst_valid", {63'd0, bus_if.out_valid}, 64'd0);
        reset = 1'b0;
        tick();

        // Basic 3-word fetch; a second start while busy must be ignored.
        a0 = acc_cnt; p0 = pop_cnt; d0 = done_cnt;
        launch(29'h100, 16'd3);
        check_val("busy_after_start", {63'd0, bus_if.busy}, 64'd1);
        bus_if.start = 1'b1; bus_if.base_addr = 29'h5000; bus_if.num_words = 16'd5;
        tick();
        bus_if.start = 1'b0;
        wait_done(200);
        repeat (3) tick();
        check_val("b_done_cnt", done_cnt - d0, 64'd1);
        check_val("b_reads",    acc_cnt - a0,  64'd3);
        check_val("b_pops",     pop_cnt - p0,  64'd3);
        check_val("b_busy_low", {63'd0, bus_if.busy}, 64'd0);

        // Backpressure: consumer stalled, reads stop once the FIFO budget is committed.
        a0 = acc_cnt; p0 = pop_cnt;
        rdy_en = 1'b0;
        launch(29'h2000, 16'd10);
        repeat (40) tick();
        check_val("bp_reads",   acc_cnt - a0, 64'd8);
        check_val("bp_read_lo", {63'd0, bus_if.avm_read},  64'd0);
        check_val("bp_valid",   {63'd0, bus_if.out_valid}, 64'd1);
        check_val("bp_head",    bus_if.out_data, exp_q[0]);
        check_val("bp_queued",  exp_q.size(), 64'd10);
        rdy_en = 1'b1;
        wait_done(400);
        check_val("bp_reads_all", acc_cnt - a0, 64'd10);
        check_val("bp_pops_all",  pop_cnt - p0, 64'd10);

        // Waitrequest held for 5 cycles on the first read.
        stall_left = 5;
        last_wait  = -1;
        launch(29'h3000, 16'd1);
        wait_done(200);
        check_val("stall_wait", last_wait, 64'd5);

        // Address wrap at the top of the 29-bit space.
        a0 = acc_cnt;
        launch(29'h1FFFFFF8, 16'd2);
        wait_done(200);
        check_val("wrap_reads", acc_cnt - a0, 64'd2);

        // Zero-length fetch: no reads, done one cycle after start, busy never rises.
        a0 = acc_cnt;
        launch(29'h700, 16'd0);
        check_val("z_done_hi", {63'd0, bus_if.done}, 64'd1);
        check_val("z_busy",    {63'd0, bus_if.busy}, 64'd0);
        tick();
        check_val("z_done_lo", {63'd0, bus_if.done}, 64'd0);
        repeat (5) tick();
        check_val("z_reads", acc_cnt - a0, 64'd0);

        // Reset with three reads in flight; their late responses must be dropped.
        lat = 12;
        d0  = done_cnt;
        launch(29'h4000, 16'd8);
        k = 0;
        while ((model_outst != 3) && (k < 30)) begin
            tick();
            k++;
        end
        check_val("ra_outst3", model_outst, 64'd3);
        stall_left = 1000;
        reset      = 1'b1;
        exp_q.delete();
        addr_exp_q.delete();
        repeat (2) tick();
        reset      = 1'b0;
        stall_left = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (bus_if.out_valid !== 1'b0) check_val("ra_valid", {63'd0, bus_if.out_valid}, 64'd0);
        end
        check_val("ra_valid_end", {63'd0, bus_if.out_valid}, 64'd0);
        check_val("ra_late_sent", pipe.size(), 64'd0);
        check_val("ra_no_done",   done_cnt - d0, 64'd0);
        check_val("ra_busy",      {63'd0, bus_if.busy}, 64'd0);

        // Normal operation resumes after the abort.
        lat = 2;
        p0  = pop_cnt;
        launch(29'h8000, 16'd2);
        wait_done(200);
        check_val("rec_pops", pop_cnt - p0, 64'd2);
        check_val("sb_empty", exp_q.size() + addr_exp_q.size(), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_reader.md
MEM_READER -- requirements
Module: mem_reader

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, output FIFO entries (power of two, 4..64).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4, maximum in-flight Avalon reads (1..FIFO_DEPTH).
REQ-003 SHALL use one clock and a synchronous, active-high reset, ports as listed below.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to begin a burst fetch.
REQ-007 base_addr  in  29  byte address of first 64-bit word; bits [2:0] ignored (treated as 0).
REQ-008 num_words  in  16  number of 64-bit words to fetch.
REQ-009 busy  out  1  fetch in progress.
REQ-010 done  out  1  one-cycle pulse at fetch completion.
REQ-011 avm_addr  out  29  Avalon read address, to avalon_master_0_conduit_end_avm_addr.
REQ-012 avm_read  out  1  Avalon read request.
REQ-013 avm_readdata  in  64  Avalon read data.
REQ-014 avm_readdatavalid  in  1  Avalon read data qualifier.
REQ-015 avm_waitrequest  in  1  Avalon stall; request not accepted while high.
REQ-016 out_valid  out  1  out_data holds a word.
REQ-017 out_data  out  64  fetched word, in address order.
REQ-018 out_ready  in  1  consumer accepts word when out_valid and out_ready both high.

Function
REQ-019 SHALL implement states IDLE, FETCH, DRAIN; IDLE->FETCH on start in IDLE with num_words != 0; FETCH->DRAIN when the last read response is received; DRAIN->IDLE when the FIFO is empty and the final word has been popped.
REQ-020 SHALL latch base_addr (low 3 bits zeroed) and num_words on an accepted start; start outside IDLE SHALL be ignored.
REQ-021 start in IDLE with num_words == 0 SHALL issue no reads, keep busy low, and pulse done on the following cycle.
REQ-022 busy SHALL be high from the cycle after an accepted start until the cycle after the transition to IDLE.
REQ-023 done SHALL pulse for exactly one cycle, in the cycle after the last word is popped (DRAIN->IDLE).
REQ-024 A read SHALL be accepted in a cycle with avm_read high and avm_waitrequest low.
REQ-025 While avm_read is high and avm_waitrequest is high, avm_read and avm_addr SHALL hold stable.
REQ-026 avm_read SHALL be asserted only when requests remain, outstanding < MAX_OUTSTANDING, and outstanding + fifo_count < FIFO_DEPTH; this guarantees the FIFO never overflows.
REQ-027 avm_addr SHALL start at the latched base and advance by 8 after each accepted read, wrapping modulo 2^29.
REQ-028 The outstanding counter SHALL increment on accept, decrement on readdatavalid, and stay unchanged when both occur in the same cycle.
REQ-029 Each avm_readdatavalid with outstanding > 0 SHALL write avm_readdata into the FIFO; readdatavalid with outstanding == 0 SHALL be ignored.
REQ-030 The FIFO SHALL be first-word-fall-through: a word written in cycle N is visible on out_valid/out_data in cycle N+1.
REQ-031 A simultaneous FIFO write and pop SHALL leave fifo_count unchanged.
REQ-032 With out_ready low, out_valid and out_data SHALL hold stable.
REQ-033 Words SHALL be delivered in issue order, with no loss or duplication.

Reset
REQ-034 Reset SHALL force IDLE and clear to 0: busy, done, avm_read, avm_addr, out_valid, outstanding, fifo_count, and the request counter.
REQ-035 Reset mid-fetch SHALL abort the fetch with no done pulse; responses from reads issued before reset SHALL be dropped under REQ-029.

Verification
REQ-036 base_addr=0x100, num_words=3, waitrequest=0, fixed 2-cycle read latency, out_ready=1 -> addresses 0x100, 0x108, 0x110; 3 words delivered in order; one done pulse; busy then low.
REQ-037 num_words=10, out_ready=0 -> exactly 8 reads accepted, then avm_read low; 8 words held. Raise out_ready -> remaining 2 reads issue; 10 words delivered in total.
REQ-038 waitrequest held high 5 cycles on the first read -> avm_addr and avm_read stable throughout; read accepted in cycle 6.
REQ-039 base_addr=0x1FFFFFF8, num_words=2 -> addresses 0x1FFFFFF8 then 0x00000000.
REQ-040 num_words=0 -> no avm_read; done pulses one cycle after start; busy stays 0. Start asserted while busy -> ignored.
REQ-041 Reset asserted with 3 reads outstanding, then 3 late readdatavalid pulses -> out_valid stays 0 and no done pulse.
